// File: rtl/multicycle_control_fsm.sv
// Main control sequencer of the multicycle CPU: walks each instruction through
// fetch/decode/execute/memory/writeback and drives ALU selects and datapath write enables.
module multicycle_control_fsm #(
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b011,
    parameter int         STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [2:0]         funct,
    input  logic               zero,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    // state    | meaning
    // RST      | held in reset, all outputs low
    // FETCH    | read instruction, load IR, PC <= PC+4
    // DECODE   | branch target into ALUOut, dispatch on opcode
    // MEM_ADDR | effective address for LW/SW
    // MEM_RD   | data memory read
    // MEM_WB   | MDR into rt
    // MEM_WR   | data memory write
    // EXEC_R   | R-type ALU op (funct)
    // R_WB     | ALUOut into rd
    // EXEC_I   | I-type ALU op (opcode[2:0])
    // I_WB     | ALUOut into rt
    // BRANCH   | BEQ compare, conditional PC load
    // JUMP     | PC <= jump target
    typedef enum logic [3:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        R_WB     = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t     cur_state, nxt_state;
    logic       pc_write, pc_write_cond;
    logic       pc_write_n, pc_write_cond_n, i_or_d_n, mem_read_n, mem_write_n;
    logic       ir_write_n, mem_to_reg_n, reg_dst_n, reg_write_n, alu_src_a_n;
    logic [1:0] alu_src_b_n, pc_source_n;
    logic [2:0] alu_op_n;
    logic       op_legal;

    assign op_legal = (opcode == OP_R) || (opcode[5:3] == 3'b001) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_J);

    // Outputs are decoded from the state being entered, so they are registered
    // yet still line up with the state they belong to.
    always_comb begin
        nxt_state       = FETCH;
        pc_write_n      = 1'b0;
        pc_write_cond_n = 1'b0;
        i_or_d_n        = 1'b0;
        mem_read_n      = 1'b0;
        mem_write_n     = 1'b0;
        ir_write_n      = 1'b0;
        mem_to_reg_n    = 1'b0;
        reg_dst_n       = 1'b0;
        reg_write_n     = 1'b0;
        alu_src_a_n     = 1'b0;
        alu_src_b_n     = 2'b00;
        alu_op_n        = ALU_ADD;
        pc_source_n     = 2'b00;

        case (cur_state)
            FETCH:    nxt_state = DECODE;
            DECODE: begin
                if (opcode == OP_R)                            nxt_state = EXEC_R;
                else if (opcode[5:3] == 3'b001)                nxt_state = EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)   nxt_state = MEM_ADDR;
                else if (opcode == OP_BEQ)                     nxt_state = BRANCH;
                else if (opcode == OP_J)                       nxt_state = JUMP;
                else                                           nxt_state = FETCH;
            end
            MEM_ADDR: nxt_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   nxt_state = MEM_WB;
            EXEC_R:   nxt_state = R_WB;
            EXEC_I:   nxt_state = I_WB;
            default:  nxt_state = FETCH;
        endcase

        case (nxt_state)
            FETCH: begin
                mem_read_n  = 1'b1;
                ir_write_n  = 1'b1;
                pc_write_n  = 1'b1;
                alu_src_b_n = 2'b01;
            end
            DECODE:   alu_src_b_n = 2'b11;
            MEM_ADDR: begin
                alu_src_a_n = 1'b1;
                alu_src_b_n = 2'b10;
            end
            MEM_RD: begin
                mem_read_n = 1'b1;
                i_or_d_n   = 1'b1;
            end
            MEM_WB: begin
                reg_write_n  = 1'b1;
                mem_to_reg_n = 1'b1;
            end
            MEM_WR: begin
                mem_write_n = 1'b1;
                i_or_d_n    = 1'b1;
            end
            EXEC_R: begin
                alu_src_a_n = 1'b1;
                alu_op_n    = funct;
            end
            R_WB: begin
                reg_write_n = 1'b1;
                reg_dst_n   = 1'b1;
            end
            EXEC_I: begin
                alu_src_a_n = 1'b1;
                alu_src_b_n = 2'b10;
                alu_op_n    = opcode[2:0];
            end
            I_WB:     reg_write_n = 1'b1;
            BRANCH: begin
                alu_src_a_n     = 1'b1;
                alu_op_n        = ALU_SUB;
                pc_write_cond_n = 1'b1;
                pc_source_n     = 2'b01;
            end
            JUMP: begin
                pc_write_n  = 1'b1;
                pc_source_n = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= RST;
            pc_write      <= 1'b0;
            pc_write_cond <= 1'b0;
            i_or_d        <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            ir_write      <= 1'b0;
            mem_to_reg    <= 1'b0;
            reg_dst       <= 1'b0;
            reg_write     <= 1'b0;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            alu_op        <= 3'b000;
            pc_source     <= 2'b00;
        end else begin
            cur_state     <= nxt_state;
            pc_write      <= pc_write_n;
            pc_write_cond <= pc_write_cond_n;
            i_or_d        <= i_or_d_n;
            mem_read      <= mem_read_n;
            mem_write     <= mem_write_n;
            ir_write      <= ir_write_n;
            mem_to_reg    <= mem_to_reg_n;
            reg_dst       <= reg_dst_n;
            reg_write     <= reg_write_n;
            alu_src_a     <= alu_src_a_n;
            alu_src_b     <= alu_src_b_n;
            alu_op        <= alu_op_n;
            pc_source     <= pc_source_n;
        end
    end

    // zero is only valid in BRANCH, so the conditional load must see it live.
    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign illegal = (cur_state == DECODE) && !op_legal;
    assign state   = STATE_W'(cur_state);

endmodule
